// File: rtl/snn_post_pkg.sv
// Shared constants for the post-neuron state update path: widths, FSM encodings and
// saturation limits of the membrane potential.
package snn_post_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int N_LANES    = 8;
  localparam int V_WIDTH    = 16;
  localparam int W_WIDTH    = 8;
  localparam int DATA_WIDTH = N_LANES * V_WIDTH;

  localparam logic signed [V_WIDTH-1:0] V_MAX = 16'sh7FFF;
  localparam logic signed [V_WIDTH-1:0] V_MIN = 16'sh8000;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;
endpackage

// File: rtl/post_neuron_lane.sv
// One neuron lane: saturating integrate of a signed weight, threshold compare and
// reset-to-zero on fire. Purely combinational.
module post_neuron_lane #(
  parameter int                    V_WIDTH   = 16,
  parameter int                    W_WIDTH   = 8,
  parameter logic signed [V_WIDTH-1:0] THRESHOLD = 16'sd100
) (
  input  logic signed [V_WIDTH-1:0] v_old,
  input  logic signed [W_WIDTH-1:0] weight,
  input  logic                      en,
  output logic signed [V_WIDTH-1:0] v_new,
  output logic                      spike
);
  logic [V_WIDTH:0]          sum;
  logic signed [V_WIDTH-1:0] sat;

  assign sum = {v_old[V_WIDTH-1], v_old}
             + {{(V_WIDTH+1-W_WIDTH){weight[W_WIDTH-1]}}, weight};

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    sat = sum[V_WIDTH-1:0];
    if (sum[V_WIDTH] != sum[V_WIDTH-1])
      sat = sum[V_WIDTH] ? {1'b1, {(V_WIDTH-1){1'b0}}} : {1'b0, {(V_WIDTH-1){1'b1}}};
  end

  assign spike = en && (sat >= THRESHOLD);
  assign v_new = !en ? v_old : (spike ? '0 : sat);
endmodule

// File: rtl/post_neuron_update_ctrl.sv
// Read-modify-write sequencer in front of the post-neuron state SRAM: clears the array
// after reset, then integrates one synaptic event per three cycles and reports spikes.
module post_neuron_update_ctrl #(
  parameter int ADDR_WIDTH = snn_post_pkg::ADDR_WIDTH,
  parameter int N_LANES    = snn_post_pkg::N_LANES,
  parameter int V_WIDTH    = snn_post_pkg::V_WIDTH,
  parameter int W_WIDTH    = snn_post_pkg::W_WIDTH,
  parameter int DATA_WIDTH = N_LANES * V_WIDTH,
  parameter logic signed [V_WIDTH-1:0] THRESHOLD = 16'sd100
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         event_valid,
  output logic                         event_ready,
  input  logic [ADDR_WIDTH-1:0]        event_addr,
  input  logic [N_LANES*W_WIDTH-1:0]   event_weight,
  input  logic [N_LANES-1:0]           event_mask,
  input  logic                         init_start,
  output logic                         init_busy,
  output logic                         spike_valid,
  output logic [ADDR_WIDTH-1:0]        spike_addr,
  output logic [N_LANES-1:0]           spike_vec,
  output logic                         sram_cs,
  output logic                         sram_we,
  output logic [ADDR_WIDTH-1:0]        sram_addr,
  output logic [DATA_WIDTH-1:0]        sram_din,
  input  logic [DATA_WIDTH-1:0]        sram_dout
);
  import snn_post_pkg::*;

  logic [1:0]                 state;
  logic [ADDR_WIDTH-1:0]      cnt;
  logic [ADDR_WIDTH-1:0]      ev_addr;
  logic [N_LANES*W_WIDTH-1:0] ev_weight;
  logic [N_LANES-1:0]         ev_mask;
  logic [N_LANES-1:0]         lane_spike;
  logic [DATA_WIDTH-1:0]      new_word;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    post_neuron_lane #(
      .V_WIDTH  (V_WIDTH),
      .W_WIDTH  (W_WIDTH),
      .THRESHOLD(THRESHOLD)
    ) u_lane (
      .v_old (sram_dout[g*V_WIDTH +: V_WIDTH]),
      .weight(ev_weight[g*W_WIDTH +: W_WIDTH]),
      .en    (ev_mask[g]),
      .v_new (new_word[g*V_WIDTH +: V_WIDTH]),
      .spike (lane_spike[g])
    );
  end

  assign event_ready = (state == ST_IDLE);
  assign init_busy   = (state == ST_INIT);
  assign sram_din    = (state == ST_WB) ? new_word : '0;

  // SRAM controls are registered from the next-state decision so each state's
  // access is presented exactly during the cycle that state is current.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_INIT;
      cnt         <= '0;
      ev_addr     <= '0;
      ev_weight   <= '0;
      ev_mask     <= '0;
      sram_cs     <= 1'b0;
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      spike_valid <= 1'b0;
      spike_vec   <= '0;
      spike_addr  <= '0;
    end else begin
      spike_valid <= 1'b0;
      spike_vec   <= '0;
      case (state)
        ST_INIT: begin
          if (sram_cs && sram_we && (sram_addr == '1)) begin
            state   <= ST_IDLE;
            sram_cs <= 1'b0;
            sram_we <= 1'b0;
          end else begin
            sram_cs   <= 1'b1;
            sram_we   <= 1'b1;
            sram_addr <= cnt;
            cnt       <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (init_start) begin
            state <= ST_INIT;
            cnt   <= '0;
          end else if (event_valid) begin
            ev_addr   <= event_addr;
            ev_weight <= event_weight;
            ev_mask   <= event_mask;
            sram_cs   <= 1'b1;
            sram_we   <= 1'b0;
            sram_addr <= event_addr;
            state     <= ST_RD;
          end
        end
        ST_RD: begin
          sram_we <= 1'b1;
          state   <= ST_WB;
        end
        ST_WB: begin
          sram_cs     <= 1'b0;
          sram_we     <= 1'b0;
          state       <= ST_IDLE;
          spike_valid <= |lane_spike;
          spike_vec   <= lane_spike;
          spike_addr  <= ev_addr;
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_post_neuron_update_ctrl.sv
// Directed bench for post_neuron_update_ctrl with a 256x128 registered-read SRAM model.
module tb_post_neuron_update_ctrl;
  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         event_valid = 1'b0;
  logic         event_ready;
  logic [7:0]   event_addr = '0;
  logic [63:0]  event_weight = '0;
  logic [7:0]   event_mask = '0;
  logic         init_start = 1'b0;
  logic         init_busy;
  logic         spike_valid;
  logic [7:0]   spike_addr;
  logic [7:0]   spike_vec;
  logic         sram_cs, sram_we;
  logic [7:0]   sram_addr;
  logic [127:0] sram_din;
  logic [127:0] sram_dout;

  logic [127:0] mem [256];
  logic         bd_we = 1'b0;
  logic [7:0]   bd_addr = '0;
  logic [127:0] bd_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  post_neuron_update_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_addr(event_addr), .event_weight(event_weight), .event_mask(event_mask),
    .init_start(init_start), .init_busy(init_busy),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .spike_vec(spike_vec),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input logic [7:0] a, input logic [127:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  task automatic sweep_check(input string tag);
    int bad = 0;
    int nz = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      if (!(sram_cs === 1'b1 && sram_we === 1'b1 && sram_addr === i[7:0] &&
            sram_din === 128'h0 && init_busy === 1'b1 && event_ready === 1'b0 &&
            spike_valid === 1'b0)) bad++;
    end
    chk({tag, "_sweep_bad_cycles"}, bad, 0);
    @(negedge CLK);
    chk({tag, "_post_ready"}, event_ready, 1'b1);
    chk({tag, "_post_busy"}, init_busy, 1'b0);
    chk({tag, "_post_cs"}, sram_cs, 1'b0);
    for (int i = 0; i < 256; i++) if (mem[i] !== 128'h0) nz++;
    chk({tag, "_mem_nonzero_words"}, nz, 0);
  endtask

  task automatic do_event(input string tag, input logic [7:0] a, input logic [63:0] w,
                          input logic [7:0] m, output logic [127:0] din,
                          output logic sv, output logic [7:0] sa, output logic [7:0] svec);
    chk({tag, "_ready_pre"}, event_ready, 1'b1);
    event_valid = 1'b1; event_addr = a; event_weight = w; event_mask = m;
    @(negedge CLK);
    event_valid = 1'b0;
    chk({tag, "_rd_ctl"}, {sram_cs, sram_we, event_ready}, 3'b100);
    chk({tag, "_rd_addr"}, sram_addr, a);
    @(negedge CLK);
    chk({tag, "_wb_ctl"}, {sram_cs, sram_we, event_ready}, 3'b110);
    chk({tag, "_wb_addr"}, sram_addr, a);
    din = sram_din;
    @(negedge CLK);
    chk({tag, "_ready_post"}, event_ready, 1'b1);
    sv = spike_valid; sa = spike_addr; svec = spike_vec;
  endtask

  logic [127:0] din;
  logic         sv;
  logic [7:0]   sa, svec;

  initial begin
    // Hold reset and fill the array with garbage so the clear sweep is observable.
    for (int i = 0; i < 256; i++) backdoor(i[7:0], {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1);
    chk("rst_ctl", {sram_cs, sram_we, event_ready, init_busy, spike_valid}, 5'b00010);
    chk("rst_spike", {spike_addr, spike_vec, sram_addr}, 24'h0);

    RST_N = 1'b1;
    sweep_check("t1");

    // Single event, +10 in every lane.
    do_event("t2", 8'd5, {8{8'd10}}, 8'hFF, din, sv, sa, svec);
    chk("t2_din", din, {8{16'h000A}});
    chk("t2_spike_valid", sv, 1'b0);
    chk("t2_spike_vec", svec, 8'h00);

    // Nine more back-to-back events; the tenth reaches 100 and fires.
    for (int k = 2; k <= 10; k++) begin
      do_event("t3", 8'd5, {8{8'd10}}, 8'hFF, din, sv, sa, svec);
      if (k == 9) begin
        chk("t3_ev9_din", din, {8{16'd90}});
        chk("t3_ev9_sv", sv, 1'b0);
      end
    end
    chk("t3_din", din, 128'h0);
    chk("t3_spike", {sv, sa, svec}, {1'b1, 8'd5, 8'hFF});
    chk("t3_mem", mem[5], 128'h0);

    // Masked lanes stay untouched even with a non-zero weight.
    do_event("t4a", 8'd7, {8{8'd50}}, 8'h0F, din, sv, sa, svec);
    chk("t4a_din", din, {{4{16'h0000}}, {4{16'h0032}}});
    chk("t4a_sv", {sv, svec}, 9'h0);
    do_event("t4b", 8'd7, {8{8'd50}}, 8'h0F, din, sv, sa, svec);
    chk("t4b_din", din, 128'h0);
    chk("t4b_spike", {sv, sa, svec}, {1'b1, 8'd7, 8'h0F});

    // Negative saturation: -32700 + -128 clamps to -32768.
    backdoor(8'd9, {8{16'h8044}});
    do_event("t5", 8'd9, {8{8'h80}}, 8'hFF, din, sv, sa, svec);
    chk("t5_din", din, {8{16'h8000}});
    chk("t5_sv", {sv, svec}, 9'h0);

    // Positive saturation to 32767 is above threshold, so it fires and clears.
    backdoor(8'd10, {8{16'd32700}});
    do_event("t5p", 8'd10, {8{8'd127}}, 8'hFF, din, sv, sa, svec);
    chk("t5p_din", din, 128'h0);
    chk("t5p_spike", {sv, sa, svec}, {1'b1, 8'd10, 8'hFF});

    // Distinct per-lane weights, including a negative one, to check lane ordering.
    do_event("t7", 8'd20, 64'hFD06_0504_0302_0100, 8'hFF, din, sv, sa, svec);
    chk("t7_din", din, 128'hFFFD_0006_0005_0004_0003_0002_0001_0000);
    chk("t7_sv", sv, 1'b0);

    // Reset during WB drops the in-flight event and reruns the sweep.
    event_valid = 1'b1; event_addr = 8'd5; event_weight = {8{8'd100}}; event_mask = 8'hFF;
    @(negedge CLK);
    event_valid = 1'b0;
    @(negedge CLK);
    chk("t6a_in_wb", {sram_cs, sram_we}, 2'b11);
    RST_N = 1'b0;
    #1;
    chk("t6a_rst_ctl", {sram_cs, sram_we, event_ready, init_busy, spike_valid}, 5'b00010);
    @(negedge CLK);
    chk("t6a_no_spike", {spike_valid, spike_vec}, 9'h0);
    RST_N = 1'b1;
    sweep_check("t6a");

    // init_start beats a simultaneous event, which is never read.
    init_start = 1'b1; event_valid = 1'b1; event_addr = 8'd3;
    event_weight = {8{8'd1}}; event_mask = 8'hFF;
    @(negedge CLK);
    init_start = 1'b0; event_valid = 1'b0;
    chk("t6b_ctl", {init_busy, event_ready, sram_cs}, 3'b100);
    sweep_check("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
